// File: rtl/comparator.sv
// Registered N-bit magnitude comparator (unsigned or two's-complement signed).
// The compare is a bit-sliced tree: per-bit greater/equal terms merged pairwise
// over log2(N) levels, MSB side taking priority at every merge.
module comparator #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         D,
    input  logic         in_valid,
    output logic         gt,
    output logic         lt,
    output logic         eq,
    output logic         out_valid
);

    // Tree is built over the next power of two; padding leaves read as "equal"
    // so they never influence the result.
    localparam int L = (N < 2) ? 1 : $clog2(N);
    localparam int P = 1 << L;

    // Flipping both sign bits maps two's-complement ordering onto unsigned
    // ordering, so one unsigned tree serves both modes; equality is unaffected.
    logic [N-1:0] sign_flip;
    logic [N-1:0] a_x;
    logic [N-1:0] b_x;

    assign sign_flip = {D, {(N-1){1'b0}}};
    assign a_x       = A ^ sign_flip;
    assign b_x       = B ^ sign_flip;

    // Heap-ordered tree: node j has children 2j (more significant half) and
    // 2j+1 (less significant half); node 1 is the root; leaves sit at P..2P-1
    // with the MSB at index P.
    logic [2*P-1:1] g_t;
    logic [2*P-1:1] e_t;

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_leaf
            if (gi < N) begin : g_real
                assign g_t[2*P-1-gi] = a_x[gi] & ~b_x[gi];
                assign e_t[2*P-1-gi] = ~(a_x[gi] ^ b_x[gi]);
            end else begin : g_pad
                assign g_t[2*P-1-gi] = 1'b0;
                assign e_t[2*P-1-gi] = 1'b1;
            end
        end

        for (gi = 1; gi < P; gi++) begin : g_node
            assign g_t[gi] = g_t[2*gi] | (e_t[2*gi] & g_t[2*gi+1]);
            assign e_t[gi] = e_t[2*gi] & e_t[2*gi+1];
        end
    endgenerate

    logic res_gt;
    logic res_eq;
    logic res_lt;

    assign res_gt = g_t[1];
    assign res_eq = e_t[1];
    assign res_lt = ~res_gt & ~res_eq;

    // Capture flags on accepted compares; flags hold otherwise, valid tracks in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                gt <= res_gt;
                lt <= res_lt;
                eq <= res_eq;
            end
        end
    end

endmodule

// File: tb/tb_comparator.sv
// Directed and swept checks for comparator at N=8.
module tb_comparator;

    localparam int N = 8;
    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_LT = 3'b010;
    localparam logic [2:0] F_EQ = 3'b001;
    localparam logic [2:0] F_0  = 3'b000;

    logic         clk;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         d;
    logic         in_valid;
    logic         gt;
    logic         lt;
    logic         eq;
    logic         out_valid;

    int errors = 0;
    int checks = 0;

    comparator #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a),
        .B         (b),
        .D         (d),
        .in_valid  (in_valid),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // got/exp are {out_valid, gt, lt, eq}
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {vld,gt,lt,eq}=%b expected %b", tag, got, exp);
        end
    endtask

    // One accepted compare, checked #1 after the accepting edge.
    task automatic cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic dv, input logic [2:0] exp);
        @(negedge clk);
        a = av;
        b = bv;
        d = dv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check(tag, {out_valid, gt, lt, eq}, {1'b1, exp});
    endtask

    task automatic idle(input string tag, input int n, input logic [2:0] held);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = 8'hA5;
            b = 8'h5A;
            d = ~d;
            @(posedge clk);
            #1;
            check(tag, {out_valid, gt, lt, eq}, {1'b0, held});
        end
    endtask

    function automatic logic [2:0] ref_flags(input logic [7:0] av, input logic [7:0] bv, input logic dv);
        if (av == bv) return F_EQ;
        if (dv) return ($signed(av) > $signed(bv)) ? F_GT : F_LT;
        return (av > bv) ? F_GT : F_LT;
    endfunction

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rd;

        rst = 1'b1;
        a = '0;
        b = '0;
        d = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_init", {out_valid, gt, lt, eq}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        idle("post_reset_idle", 1, F_0);

        // T2 unsigned
        cmp("u_4_4",   8'h04, 8'h04, 1'b0, F_EQ);
        cmp("u_4_2",   8'h04, 8'h02, 1'b0, F_GT);
        cmp("u_2_4",   8'h02, 8'h04, 1'b0, F_LT);
        cmp("u_40_20", 8'h40, 8'h20, 1'b0, F_GT);
        cmp("u_08_40", 8'h08, 8'h40, 1'b0, F_LT);

        // T3 signed
        cmp("s_32_8",  8'd32, 8'd8,  1'b1, F_GT);
        cmp("s_59_39", 8'h59, 8'h39, 1'b1, F_GT);
        cmp("s_81_01", 8'h81, 8'h01, 1'b1, F_LT);
        cmp("s_c0_08", 8'hC0, 8'h08, 1'b1, F_LT);
        cmp("s_88_40", 8'h88, 8'h40, 1'b1, F_LT);

        // T4 extremes
        cmp("s_80_ff", 8'h80, 8'hFF, 1'b1, F_LT);
        cmp("u_ff_80", 8'hFF, 8'h80, 1'b0, F_GT);
        cmp("u_80_ff", 8'h80, 8'hFF, 1'b0, F_LT);
        cmp("s_eq_80", 8'h80, 8'h80, 1'b1, F_EQ);
        cmp("u_eq_ff", 8'hFF, 8'hFF, 1'b0, F_EQ);

        // T5 mode sensitivity, back to back
        cmp("u_00_ff", 8'h00, 8'hFF, 1'b0, F_LT);
        cmp("s_00_ff", 8'h00, 8'hFF, 1'b1, F_GT);
        cmp("u_00_ff_again", 8'h00, 8'hFF, 1'b0, F_LT);

        // T6 hold
        cmp("hold_src", 8'h10, 8'h7F, 1'b1, F_LT);
        idle("hold", 3, F_LT);

        // T1 async reset mid-operation
        cmp("pre_reset", 8'h7F, 8'h10, 1'b0, F_GT);
        @(negedge clk);
        a = 8'h33;
        b = 8'h33;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {out_valid, gt, lt, eq}, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_held", {out_valid, gt, lt, eq}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        cmp("after_reset", 8'h01, 8'h02, 1'b1, F_LT);

        // Random sweep, both modes
        for (int i = 0; i < 10000; i++) begin
            ra = 8'($urandom);
            rb = (i % 16 == 0) ? ra : 8'($urandom);
            rd = 1'($urandom);
            cmp("sweep", ra, rb, rd, ref_flags(ra, rb, rd));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
